nyq_polyphase_decim: RTL and testbench

Parametrised polyphase decimating FIR (Nyquist) filter and the next generation of the fixed 4-MAC, 8-phase Nyquist block. Tap count, decimation factor, data and coefficient widths are generic. It adds an input-valid qualifier, programmable output scaling with saturation, a bypass mode and a soft clear. Coefficients and control are written through the standard block parameter-memory interface. It sits between the upstream sample source and the downstream rate-reduced chain.

---
 rtl/nyq_polyphase_decim_if.sv | 26 ++
 rtl/nyq_polyphase_decim.sv | 124 ++++++++++++
 tb/tb_nyq_polyphase_decim.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/nyq_polyphase_decim_if.sv
// Parameter-memory write port plus sample stream of the polyphase Nyquist decimator.
// The master drives writes and input samples; the slave returns the decimated output.
interface nyq_polyphase_decim_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int MEM_WIDTH  = 24,
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 24
);
  logic                        WrEn_SI;
  logic [ADDR_WIDTH-1:0]       Addr_DI;
  logic [MEM_WIDTH-1:0]        PAR_In_DI;
  logic signed [IN_WIDTH-1:0]  NYQ_In_DI;
  logic                        NYQ_InValid_SI;
  logic signed [OUT_WIDTH-1:0] NYQ_Out_DO;
  logic                        NYQ_Valid_DO;

  modport master (
    output WrEn_SI, Addr_DI, PAR_In_DI, NYQ_In_DI, NYQ_InValid_SI,
    input  NYQ_Out_DO, NYQ_Valid_DO
  );

  modport slave (
    input  WrEn_SI, Addr_DI, PAR_In_DI, NYQ_In_DI, NYQ_InValid_SI,
    output NYQ_Out_DO, NYQ_Valid_DO
  );
endinterface

// File: rtl/nyq_polyphase_decim.sv
// Transposed polyphase decimating FIR: NUM_MACS partial sums, one per future output,
// with programmable arithmetic shift, output saturation, bypass and soft clear.
module nyq_polyphase_decim #(
  parameter int ADDR_WIDTH = 6,
  parameter int MEM_WIDTH  = 24,
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 24,
  parameter int DECIM      = 8,
  parameter int NUM_MACS   = 4,
  parameter int ACC_WIDTH  = IN_WIDTH + MEM_WIDTH + $clog2(DECIM * NUM_MACS)
) (
  input logic Clk_CI,
  input logic Rst_RBI,
  nyq_polyphase_decim_if.slave nyq
);

  localparam int TAPS   = DECIM * NUM_MACS;
  localparam int TAP_W  = $clog2(TAPS);
  localparam int PH_W   = $clog2(DECIM);
  localparam int PROD_W = IN_WIDTH + MEM_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR  = '1;
  localparam logic [ADDR_WIDTH-1:0] TAPS_ADDR  = ADDR_WIDTH'(TAPS);
  localparam logic [PH_W-1:0]       LAST_PHASE = PH_W'(DECIM - 1);

  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [MEM_WIDTH-1:0]         coef_mem [TAPS];
  logic                         bypass;
  logic [4:0]                   shift;
  logic [PH_W-1:0]              phase;
  logic signed [ACC_WIDTH-1:0]  acc  [NUM_MACS];
  logic signed [MEM_WIDTH-1:0]  coef [NUM_MACS];
  logic signed [PROD_W-1:0]     prod [NUM_MACS];
  logic signed [ACC_WIDTH-1:0]  sum  [NUM_MACS];
  logic signed [IN_WIDTH-1:0]   sample;
  logic signed [ACC_WIDTH-1:0]  scaled;
  logic signed [OUT_WIDTH-1:0]  out_q;
  logic                         valid_q;
  logic                         accept;
  logic                         ctrl_write;
  logic                         coef_write;
  logic                         clr_write;

  function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
    if (v > OUT_MAX)
      return OUT_MAX[OUT_WIDTH-1:0];
    else if (v < OUT_MIN)
      return OUT_MIN[OUT_WIDTH-1:0];
    else
      return v[OUT_WIDTH-1:0];
  endfunction

  // A write cycle always wins over a sample presented in the same cycle.
  assign accept     = nyq.NYQ_InValid_SI && !nyq.WrEn_SI;
  assign ctrl_write = nyq.WrEn_SI && (nyq.Addr_DI == CTRL_ADDR);
  assign coef_write = nyq.WrEn_SI && (nyq.Addr_DI < TAPS_ADDR);
  assign clr_write  = ctrl_write && nyq.PAR_In_DI[6];
  assign sample     = nyq.NYQ_In_DI;

  assign nyq.NYQ_Out_DO   = out_q;
  assign nyq.NYQ_Valid_DO = valid_q;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      for (int k = 0; k < TAPS; k++) coef_mem[k] <= '0;
    end else if (coef_write) begin
      coef_mem[TAP_W'(nyq.Addr_DI)] <= nyq.PAR_In_DI;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      bypass <= 1'b0;
      shift  <= '0;
    end else if (ctrl_write) begin
      bypass <= nyq.PAR_In_DI[0];
      shift  <= nyq.PAR_In_DI[5:1];
    end
  end

  // Sample at phase p in block j feeds output j+m through tap m*DECIM + DECIM-1-p.
  always_comb begin
    for (int m = 0; m < NUM_MACS; m++) begin
      coef[m] = coef_mem[TAP_W'(m * DECIM + DECIM - 1 - int'(phase))];
      prod[m] = PROD_W'(sample) * PROD_W'(coef[m]);
      sum[m]  = acc[m] + ACC_WIDTH'(prod[m]);
    end
    scaled = sum[0] >>> shift;
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      phase   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      for (int m = 0; m < NUM_MACS; m++) acc[m] <= '0;
    end else begin
      valid_q <= 1'b0;
      if (clr_write) begin
        phase <= '0;
        for (int m = 0; m < NUM_MACS; m++) acc[m] <= '0;
      end else if (accept && bypass) begin
        out_q   <= saturate(ACC_WIDTH'(sample));
        valid_q <= 1'b1;
        phase   <= '0;
        for (int m = 0; m < NUM_MACS; m++) acc[m] <= '0;
      end else if (accept && phase == LAST_PHASE) begin
        out_q   <= saturate(scaled);
        valid_q <= 1'b1;
        phase   <= '0;
        for (int m = 0; m < NUM_MACS - 1; m++) acc[m] <= sum[m+1];
        acc[NUM_MACS-1] <= '0;
      end else if (accept) begin
        phase <= phase + 1'b1;
        for (int m = 0; m < NUM_MACS; m++) acc[m] <= sum[m];
      end
    end
  end

endmodule

// File: tb/tb_nyq_polyphase_decim.sv
// Scoreboard bench for nyq_polyphase_decim: a direct-form reference model queues expected
// outputs with their due cycle as stimulus is driven; a monitor pops and compares.
module tb_nyq_polyphase_decim;
  localparam int ADDR_WIDTH = 6;
  localparam int MEM_WIDTH  = 24;
  localparam int IN_WIDTH   = 24;
  localparam int OUT_WIDTH  = 24;
  localparam int DECIM      = 8;
  localparam int NUM_MACS   = 4;
  localparam int TAPS       = DECIM * NUM_MACS;
  localparam int CTRL_ADDR  = 2**ADDR_WIDTH - 1;
  localparam int CLR        = 64;
  localparam longint OUT_MAX = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
  localparam longint OUT_MIN = -(longint'(1) <<< (OUT_WIDTH - 1));

  typedef struct {
    longint value;
    int     cycle;
  } expect_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int cycleCount = 0;
  int checks = 0;
  int errors = 0;

  expect_t expQ[$];
  longint  hModel[TAPS];
  longint  xHist[$];
  bit      bypassModel;
  int      shiftModel;

  nyq_polyphase_decim_if #(
    .ADDR_WIDTH(ADDR_WIDTH), .MEM_WIDTH(MEM_WIDTH),
    .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)
  ) nyq ();

  nyq_polyphase_decim #(
    .ADDR_WIDTH(ADDR_WIDTH), .MEM_WIDTH(MEM_WIDTH), .IN_WIDTH(IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH), .DECIM(DECIM), .NUM_MACS(NUM_MACS)
  ) dut (
    .Clk_CI (clk),
    .Rst_RBI(rst_n),
    .nyq    (nyq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount++;

  function automatic longint satOut(longint v);
    if (v > OUT_MAX) return OUT_MAX;
    if (v < OUT_MIN) return OUT_MIN;
    return v;
  endfunction

  task automatic checkOutput(string tag, longint actual, longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < TAPS; k++) hModel[k] = 0;
    xHist.delete();
    expQ.delete();
    bypassModel = 1'b0;
    shiftModel  = 0;
  endtask

  task automatic modelWrite(int addr, longint data);
    logic signed [MEM_WIDTH-1:0] d;
    d = data[MEM_WIDTH-1:0];
    if (addr < TAPS) begin
      hModel[addr] = d;
    end else if (addr == CTRL_ADDR) begin
      bypassModel = data[0];
      shiftModel  = int'(data[5:1]);
      if (data[6]) xHist.delete();
    end
  endtask

  // Direct-form evaluation of y[j] over the accepted-sample history since the last flush.
  task automatic modelSample(longint x);
    longint acc;
    int n, j, idx;
    if (bypassModel) begin
      xHist.delete();
      expQ.push_back('{satOut(x), cycleCount + 1});
    end else begin
      xHist.push_back(x);
      n = xHist.size() - 1;
      if (n % DECIM == DECIM - 1) begin
        j = n / DECIM;
        acc = 0;
        for (int k = 0; k < TAPS; k++) begin
          idx = j * DECIM + DECIM - 1 - k;
          if (idx >= 0) acc += hModel[k] * xHist[idx];
        end
        expQ.push_back('{satOut(acc >>> shiftModel), cycleCount + 1});
      end
    end
  endtask

  task automatic applyStimulus(bit wr, int addr, longint data, longint x, bit vld);
    nyq.WrEn_SI        = wr;
    nyq.Addr_DI        = ADDR_WIDTH'(addr);
    nyq.PAR_In_DI      = MEM_WIDTH'(data);
    nyq.NYQ_In_DI      = IN_WIDTH'(x);
    nyq.NYQ_InValid_SI = vld;
    if (wr) modelWrite(addr, data);
    else if (vld) modelSample(x);
    @(negedge clk);
  endtask

  task automatic writeParam(int addr, longint data);
    applyStimulus(1'b1, addr, data, 0, 1'b0);
  endtask

  task automatic sendSample(longint x);
    applyStimulus(1'b0, 0, 0, x, 1'b1);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 0, 0, 1'b0);
  endtask

  // Every pulse must match the head of the queue in value and cycle; overdue entries are misses.
  always @(posedge clk) begin : monitor
    expect_t e;
    #1;
    if (nyq.NYQ_Valid_DO === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_valid", nyq.NYQ_Valid_DO, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("out", nyq.NYQ_Out_DO, e.value);
        checkOutput("latency", cycleCount, e.cycle);
      end
    end else if (expQ.size() > 0 && expQ[0].cycle <= cycleCount) begin
      checkOutput("missing_valid", nyq.NYQ_Valid_DO, 1);
      void'(expQ.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nyq.WrEn_SI        = 1'b0;
    nyq.Addr_DI        = '0;
    nyq.PAR_In_DI      = '0;
    nyq.NYQ_In_DI      = '0;
    nyq.NYQ_InValid_SI = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_out", nyq.NYQ_Out_DO, 0);
    checkOutput("reset_valid", nyq.NYQ_Valid_DO, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Impulse through ramp taps
    for (int k = 0; k < TAPS; k++) writeParam(k, k + 1);
    sendSample(1);
    repeat (39) sendSample(0);

    // DC, unscaled then scaled by 2^-5
    for (int k = 0; k < TAPS; k++) writeParam(k, 1);
    writeParam(CTRL_ADDR, CLR);
    repeat (40) sendSample(1000);
    writeParam(CTRL_ADDR, CLR | (5 << 1));
    repeat (40) sendSample(1000);

    // Saturation at both rails
    for (int k = 0; k < TAPS; k++) writeParam(k, OUT_MAX);
    writeParam(CTRL_ADDR, CLR);
    repeat (24) sendSample(OUT_MAX);
    writeParam(CTRL_ADDR, CLR);
    repeat (24) sendSample(OUT_MIN);

    // Gapped impulse with three blocked samples during writes to an unused address
    for (int k = 0; k < TAPS; k++) writeParam(k, k + 1);
    writeParam(CTRL_ADDR, CLR);
    for (int i = 0; i < 40; i++) begin
      if (i == 12) repeat (3) applyStimulus(1'b1, 40, 5, 999, 1'b1);
      sendSample(i == 0 ? 1 : 0);
      idle();
    end

    // Signed random taps and data with random gaps and a shift
    for (int k = 0; k < TAPS; k++) writeParam(k, longint'(int'($urandom_range(0, 4000)) - 2000));
    writeParam(CTRL_ADDR, CLR | (10 << 1));
    for (int i = 0; i < 96; i++) begin
      if ($urandom_range(0, 3) != 0) sendSample(longint'(int'($urandom_range(0, 400000)) - 200000));
      else idle();
    end

    // Bypass, then clear keeps the held output
    writeParam(CTRL_ADDR, 1);
    sendSample(-5);
    sendSample(7);
    sendSample(123);
    sendSample(77);
    idle();
    writeParam(CTRL_ADDR, CLR);
    checkOutput("clr_keeps_out", nyq.NYQ_Out_DO, 77);

    // Clear after 5 samples restarts the block
    repeat (5) sendSample(1000);
    writeParam(CTRL_ADDR, CLR);
    repeat (8) sendSample(1000);

    // Asynchronous reset mid-accumulation
    repeat (5) sendSample(1000);
    idle();
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_rst_out", nyq.NYQ_Out_DO, 0);
    checkOutput("async_rst_valid", nyq.NYQ_Valid_DO, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (8) sendSample(1);
    for (int k = 0; k < TAPS; k++) writeParam(k, 1);
    writeParam(CTRL_ADDR, CLR);
    repeat (8) sendSample(1);

    repeat (4) idle();
    checkOutput("drain", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
